dac_frame_arbiter: RTL
======================

Name: dac_frame_arbiter

Overview:
- Shares one DAC SPI main (16-bit word plus 2-bit power_state, csb/sclk/mosi) between two sample producers, e.g. two DDS channels.
- Buffers one sample per channel and arbitrates round-robin.
- Issues a one-cycle load to the SPI main only while it is idle, then waits for the frame to finish.
- Enforces a minimum csb-high gap before the next load.

Parameters:
- WORD_WIDTH, 16: sample width; must match the SPI main.
- GAP_CYCLES, 2: extra idle sys_clk cycles after csb rises, before the next load (0 allowed).
- TIMEOUT_CYCLES, 4: cycles to wait for csb to fall after a load before flagging an error.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch0_valid  in  1  channel 0 sample valid.
- ch0_data  in  WORD_WIDTH  channel 0 sample.
- ch0_pwr  in  2  channel 0 power_state.
- ch0_ready  out  1  channel 0 holding register empty.
- ch1_valid, ch1_data, ch1_pwr, ch1_ready: same as channel 0, for channel 1.
- spi_load  out  1  load strobe to the SPI main.
- spi_word  out  WORD_WIDTH  parallel_in to the SPI main.
- spi_pwr  out  2  power_state to the SPI main.
- spi_csb  in  1  csb returned from the SPI main; high = idle.
- grant  out  1  channel whose frame is in flight or was last issued.
- frame_done  out  1  one-cycle pulse when csb is seen rising.
- spi_err  out  1  sticky; set on timeout.

Behaviour:
- Reset values: all outputs 0 except ch0_ready=1 and ch1_ready=1. Holding registers empty, state IDLE, last_grant=1 so channel 0 wins first.
- Per channel: one-entry holding register {pwr, data} with a full flag.
  - chN_ready = ~fullN, registered; no combinational path from valid.
  - A sample is captured on valid & ready.
  - full clears on the cycle the channel is granted (IDLE->ISSUE). ready rises the next cycle.
- States:
  - IDLE: if any channel is full, grant it and move to ISSUE. If both are full, grant ~last_grant. On the transition, latch spi_word/spi_pwr from the granted register and update last_grant and grant.
  - ISSUE: spi_load=1 for exactly this one cycle. Go to WAIT_START and load the timeout counter with TIMEOUT_CYCLES.
  - WAIT_START: csb sampled low -> WAIT_DONE. Otherwise decrement the counter; at 0, set spi_err and go to IDLE (sample is dropped).
  - WAIT_DONE: csb sampled high -> pulse frame_done. Go to GAP with counter GAP_CYCLES, or to IDLE if GAP_CYCLES=0.
  - GAP: decrement the counter; at 1 (or 0), go to IDLE.
- Timing (SPI main loads on the falling edge after the load cycle):
  - csb is low for WORD_WIDTH+2 cycles.
  - Back-to-back load pulses are spaced exactly WORD_WIDTH+4+GAP_CYCLES cycles (22 with defaults).
- spi_load is never asserted while csb is low or outside ISSUE.
- spi_word/spi_pwr hold stable from ISSUE until the next grant.
- A capture on channel N in the same cycle that channel N is granted cannot occur, because ready is low while full.
- Reset mid-frame: the controller returns to IDLE and both holding registers empty. Any frame already started in the SPI main completes on its own.
- If csb is high again in the very first WAIT_DONE sample, treat it as frame done.

Optional Feature:
- DAC_ARB_STATS_EN defined:
  - Adds outputs ch0_frames and ch1_frames, 16 bits each. The count for the granted channel increments on each frame_done and saturates at 0xFFFF.
  - Adds output drop_cnt, 8 bits. It increments, saturating, on each timeout.
  - All three counters reset to 0.
- Not defined: these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the state encoding enum (IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP);
  - the constant SPI_PWR_W=2;
  - the frame-length function WORD_WIDTH+2.
- One natural sub-module, dac_sample_slot: the per-channel holding register with full flag and ready. It is instantiated twice.

Test Plan:
- Reset, then ch0 presents 0x1234 with pwr=0:
  - spi_load is high for 1 cycle, with spi_word=0x1234, spi_pwr=0, grant=0;
  - frame_done follows 19 cycles after the load, and the SPI model shifts out 00_0001001000110100.
- Both channels continuously valid (ch0 0xAAAA, ch1 0x5555):
  - grants alternate 0,1,0,1;
  - load pulses are 22 cycles apart;
  - spi_load is never high while csb is low.
- ch1 writes while full: ch1_ready=0 and the second value is not captured. After grant, ready rises and the next value is accepted.
- SPI model holds csb high after a load: spi_err sets after 4 cycles, the state returns to IDLE, and the next sample still issues.
- Assert rst_n low during WAIT_DONE with both slots full: all outputs go to reset values immediately and ready=1. After release, the first grant goes to ch0.
- With DAC_ARB_STATS_EN defined: after 3 ch0 frames and 1 timeout, ch0_frames=3, ch1_frames=0, drop_cnt=1.

Source files
------------

// File: rtl/dac_frame_arbiter_pkg.sv
// Shared types and constants for the two-channel DAC frame arbiter.
package dac_frame_arbiter_pkg;

    localparam int SPI_PWR_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_GAP        = 3'd4
    } arb_state_e;

    // Number of sys_clk cycles csb stays low for one frame.
    function automatic int frame_cycles(input int word_width);
        return word_width + 2;
    endfunction

endpackage

// File: rtl/dac_frame_arbiter_if.sv
// Producer and SPI-main signals of the DAC frame arbiter, with the arbiter as the slave side.
interface dac_frame_arbiter_if
    import dac_frame_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 16
);
    // Handshake: a sample moves on a rising edge where chN_valid and chN_ready are both high;
    // chN_ready comes straight from a flop and never depends on chN_valid in the same cycle.
    logic                  ch0_valid;
    logic [WORD_WIDTH-1:0] ch0_data;
    logic [SPI_PWR_W-1:0]  ch0_pwr;
    logic                  ch0_ready;
    logic                  ch1_valid;
    logic [WORD_WIDTH-1:0] ch1_data;
    logic [SPI_PWR_W-1:0]  ch1_pwr;
    logic                  ch1_ready;
    logic                  spi_load;
    logic [WORD_WIDTH-1:0] spi_word;
    logic [SPI_PWR_W-1:0]  spi_pwr;
    logic                  spi_csb;
    logic                  grant;
    logic                  frame_done;
    logic                  spi_err;
    arb_state_e            dbg_state;

    modport master (
        output ch0_valid, ch0_data, ch0_pwr, ch1_valid, ch1_data, ch1_pwr, spi_csb,
        input  ch0_ready, ch1_ready, spi_load, spi_word, spi_pwr, grant, frame_done, spi_err,
               dbg_state
    );

    modport slave (
        input  ch0_valid, ch0_data, ch0_pwr, ch1_valid, ch1_data, ch1_pwr, spi_csb,
        output ch0_ready, ch1_ready, spi_load, spi_word, spi_pwr, grant, frame_done, spi_err,
               dbg_state
    );

endinterface

// File: rtl/dac_sample_slot.sv
// One-entry holding register {pwr, data} with a full flag; ready is simply "not full".
module dac_sample_slot
    import dac_frame_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic [SPI_PWR_W-1:0]  in_pwr,
    input  logic                  take,
    output logic                  ready,
    output logic                  full,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [SPI_PWR_W-1:0]  out_pwr
);

    logic                  full_q, full_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic [SPI_PWR_W-1:0]  pwr_q, pwr_d;

    // take is only raised while full, so it never collides with a capture.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        pwr_d  = pwr_q;
        if (take) begin
            full_d = 1'b0;
        end else if (in_valid && !full_q) begin
            full_d = 1'b1;
            data_d = in_data;
            pwr_d  = in_pwr;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            pwr_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            pwr_q  <= pwr_d;
        end
    end

    assign ready    = ~full_q;
    assign full     = full_q;
    assign out_data = data_q;
    assign out_pwr  = pwr_q;

endmodule

// File: rtl/dac_frame_arbiter.sv
// Round-robin arbiter feeding one DAC SPI main from two sample producers.
// Optional per-channel frame and drop counters are built when DAC_ARB_STATS_EN is defined.
module dac_frame_arbiter
    import dac_frame_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH     = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic        sys_clk,
    input  logic        rst_n,
`ifdef DAC_ARB_STATS_EN
    output logic [15:0] ch0_frames,
    output logic [15:0] ch1_frames,
    output logic [7:0]  drop_cnt,
`endif
    dac_frame_arbiter_if.slave bus
);

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    logic                  full0, full1, take0, take1;
    logic [WORD_WIDTH-1:0] data0, data1;
    logic [SPI_PWR_W-1:0]  pwr0, pwr1;

    dac_sample_slot #(.WORD_WIDTH(WORD_WIDTH)) u_slot0 (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .in_valid(bus.ch0_valid),
        .in_data (bus.ch0_data),
        .in_pwr  (bus.ch0_pwr),
        .take    (take0),
        .ready   (bus.ch0_ready),
        .full    (full0),
        .out_data(data0),
        .out_pwr (pwr0)
    );

    dac_sample_slot #(.WORD_WIDTH(WORD_WIDTH)) u_slot1 (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .in_valid(bus.ch1_valid),
        .in_data (bus.ch1_data),
        .in_pwr  (bus.ch1_pwr),
        .take    (take1),
        .ready   (bus.ch1_ready),
        .full    (full1),
        .out_data(data1),
        .out_pwr (pwr1)
    );

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic                  load_q, load_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [SPI_PWR_W-1:0]  pwr_q, pwr_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  pick;
    logic                  timeout_hit;
    logic                  frame_seen;

    assign timeout_hit = (state_q == ST_WAIT_START) && bus.spi_csb && (cnt_q <= CNT_W'(1));
    assign frame_seen  = (state_q == ST_WAIT_DONE) && bus.spi_csb;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        load_d       = 1'b0;
        word_d       = word_q;
        pwr_d        = pwr_q;
        done_d       = 1'b0;
        err_d        = err_q;
        take0        = 1'b0;
        take1        = 1'b0;
        pick         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A load is only offered once the SPI main reports idle (csb high).
                if ((full0 || full1) && bus.spi_csb) begin
                    pick         = (full0 && full1) ? ~last_grant_q : full1;
                    take0        = ~pick;
                    take1        = pick;
                    grant_d      = pick;
                    last_grant_d = pick;
                    word_d       = pick ? data1 : data0;
                    pwr_d        = pick ? pwr1 : pwr0;
                    load_d       = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(TIMEOUT_CYCLES);
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!bus.spi_csb) begin
                    state_d = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (frame_seen) begin
                    done_d  = 1'b1;
                    cnt_d   = CNT_W'(GAP_CYCLES);
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            load_q       <= 1'b0;
            word_q       <= '0;
            pwr_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            load_q       <= load_d;
            word_q       <= word_d;
            pwr_q        <= pwr_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.spi_load   = load_q;
    assign bus.spi_word   = word_q;
    assign bus.spi_pwr    = pwr_q;
    assign bus.grant      = grant_q;
    assign bus.frame_done = done_q;
    assign bus.spi_err    = err_q;
    assign bus.dbg_state  = state_q;

`ifdef DAC_ARB_STATS_EN
    logic [15:0] ch0_frames_q, ch0_frames_d;
    logic [15:0] ch1_frames_q, ch1_frames_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    // grant_q still names the channel whose frame is finishing.
    always_comb begin
        ch0_frames_d = ch0_frames_q;
        ch1_frames_d = ch1_frames_q;
        drop_cnt_d   = drop_cnt_q;
        if (frame_seen && !grant_q && (ch0_frames_q != 16'hFFFF)) ch0_frames_d = ch0_frames_q + 16'd1;
        if (frame_seen && grant_q && (ch1_frames_q != 16'hFFFF))  ch1_frames_d = ch1_frames_q + 16'd1;
        if (timeout_hit && (drop_cnt_q != 8'hFF))                 drop_cnt_d   = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ch0_frames_q <= '0;
            ch1_frames_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            ch0_frames_q <= ch0_frames_d;
            ch1_frames_q <= ch1_frames_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign ch0_frames = ch0_frames_q;
    assign ch1_frames = ch1_frames_q;
    assign drop_cnt   = drop_cnt_q;
`endif

endmodule
